// File: rtl/spmmio_sdcard_spi.sv
// SPI mode-0 byte engine for an SD card: one byte per start, runtime SCK divider, chip select.
// Optional CRC-16/CCITT over MOSI or MISO bits when SDCARD_SPI_CRC16_EN is defined.
module spmmio_sdcard_spi (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [0:7]  tx_byte,
    input  logic [0:7]  div,
    input  logic        cs_en,
    input  logic        crc_clear,
    input  logic        crc_src,
    output logic        busy,
    output logic        done,
    output logic [0:7]  rx_byte,
    output logic [0:15] crc16,
    output logic        sdcard_cs,
    output logic        sdcard_sck,
    output logic        sdcard_mosi,
    input  logic        sdcard_miso
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOW  = 2'd1;
    localparam logic [1:0] HIGH = 2'd2;

    logic [1:0] r_state;
    logic [7:0] r_div;
    logic [7:0] r_cnt;
    logic [2:0] r_bit;
    logic [0:7] r_tx;
    logic [0:7] r_rx_sh;
    logic [0:7] r_rx_byte;
    logic       r_busy;
    logic       r_done;
    logic       r_sck;
    logic       r_mosi;
    logic       r_cs;
    logic       r_miso_q;

    logic       w_phase_end;
    logic       w_sample;
    logic [0:7] w_rx_shift;

    assign w_phase_end = (r_cnt == r_div);
    // MISO is taken one cycle into the high phase so the synchronising flop has
    // already captured the level present when SCK rose, even for div=0.
    assign w_sample    = (r_state == HIGH) && (r_cnt == 8'd0);
    assign w_rx_shift  = {r_rx_sh[1:7], r_miso_q};

    // NOTE: all state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_div     <= 8'd0;
            r_cnt     <= 8'd0;
            r_bit     <= 3'd0;
            r_tx      <= 8'hFF;
            r_rx_sh   <= 8'h00;
            r_rx_byte <= 8'h00;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b1;
            r_cs      <= 1'b1;
            r_miso_q  <= 1'b0;
        end else begin
            r_cs     <= ~cs_en;
            r_miso_q <= sdcard_miso;
            r_done   <= 1'b0;
            case (r_state)
                IDLE: begin
                    // The done cycle itself never accepts; a held start is taken one cycle later.
                    if (start && !r_done) begin
                        r_state <= LOW;
                        r_busy  <= 1'b1;
                        r_tx    <= tx_byte;
                        r_div   <= div;
                        r_cnt   <= 8'd0;
                        r_bit   <= 3'd0;
                        r_mosi  <= tx_byte[0];
                    end
                end
                LOW: begin
                    if (w_phase_end) begin
                        r_state <= HIGH;
                        r_sck   <= 1'b1;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                HIGH: begin
                    if (w_sample)
                        r_rx_sh <= w_rx_shift;
                    if (w_phase_end) begin
                        r_cnt <= 8'd0;
                        r_sck <= 1'b0;
                        if (r_bit == 3'd7) begin
                            r_state   <= IDLE;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_mosi    <= 1'b1;
                            r_rx_byte <= w_sample ? w_rx_shift : r_rx_sh;
                        end else begin
                            r_state <= LOW;
                            r_bit   <= r_bit + 3'd1;
                            r_tx    <= {r_tx[1:7], 1'b1};
                            r_mosi  <= r_tx[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_sck   <= 1'b0;
                    r_mosi  <= 1'b1;
                end
            endcase
        end
    end

`ifdef SDCARD_SPI_CRC16_EN
    logic [15:0] r_crc;
    logic        w_crc_bit;
    logic        w_crc_fb;

    assign w_crc_bit = crc_src ? r_miso_q : r_mosi;
    assign w_crc_fb  = r_crc[15] ^ w_crc_bit;

    always_ff @(posedge clk) begin
        if (reset || crc_clear)
            r_crc <= 16'h0000;
        else if (w_sample)
            r_crc <= {r_crc[14:0], 1'b0} ^ (w_crc_fb ? 16'h1021 : 16'h0000);
    end

    assign crc16 = r_crc;
`else
    logic w_unused_crc;
    assign w_unused_crc = crc_clear ^ crc_src;
    assign crc16        = 16'h0000;
`endif

    assign busy        = r_busy;
    assign done        = r_done;
    assign rx_byte     = r_rx_byte;
    assign sdcard_cs   = r_cs;
    assign sdcard_sck  = r_sck;
    assign sdcard_mosi = r_mosi;

endmodule
